lcd_spi_sink: RTL and testbench

- Receive-side counterpart of the LCD SPI write path. Decodes the 4-wire LCD SPI stream (cs, dc/rs, sdi, sck) into command bytes and RGB565 pixel writes with (x, y) coordinates.
- Used as an LCD model for on-chip loopback checking and as a framebuffer-capture front end.
- Tracks the column/page windows (0x2A/0x2B), memory write (0x2C) and memory write continue (0x3C).

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_spi_byte_rx.sv | 94 +++++++++
 rtl/lcd_spi_sink.sv | 237 +++++++++++++++++++++++
 tb/tb_lcd_spi_sink.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD SPI sink: controller command codes
// and the command-decoder state encoding.
package lcd_pkg;

   localparam logic [7:0] CMD_CASET  = 8'h2A;
   localparam logic [7:0] CMD_PASET  = 8'h2B;
   localparam logic [7:0] CMD_RAMWR  = 8'h2C;
   localparam logic [7:0] CMD_RAMWRC = 8'h3C;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CASET = 3'd1,
      S_PASET = 3'd2,
      S_RAMWR = 3'd3,
      S_SKIP  = 3'd4
   } lcd_state_e;

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Brings the asynchronous 4-wire LCD SPI lines into the system clock domain
// and assembles MSB-first bytes, strobing each completed byte once.
module lcd_spi_byte_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       srst,
   input  logic       cs_n,
   input  logic       dcrs,
   input  logic       sdi,
   input  logic       sck,
   output logic [7:0] rx_byte,
   output logic       rx_is_data,
   output logic       rx_stb
);

   logic [1:0] cs_sync_q, cs_sync_d;
   logic [1:0] dcrs_sync_q, dcrs_sync_d;
   logic [1:0] sdi_sync_q, sdi_sync_d;
   logic [2:0] sck_sync_q, sck_sync_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte_q, byte_d;
   logic       data_q, data_d;
   logic       done_q, done_d;
   logic       stb_q, stb_d;
   logic       sck_rise_s;

   // Synchroniser chains, bit counter and byte assembly.
   always_comb begin
      cs_sync_d   = {cs_sync_q[0], cs_n};
      dcrs_sync_d = {dcrs_sync_q[0], dcrs};
      sdi_sync_d  = {sdi_sync_q[0], sdi};
      sck_sync_d  = {sck_sync_q[1:0], sck};
      sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      data_d      = data_q;
      done_d      = 1'b0;
      // The extra pipeline stage gives a fixed four-cycle strobe latency.
      stb_d       = done_q;
      if (srst) begin
         cnt_d   = 3'd0;
         shift_d = 8'h00;
         stb_d   = 1'b0;
      end else if (cs_sync_q[1]) begin
         cnt_d = 3'd0;
      end else if (sck_rise_s) begin
         shift_d = {shift_q[6:0], sdi_sync_q[1]};
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            done_d = 1'b1;
            byte_d = {shift_q[6:0], sdi_sync_q[1]};
            data_d = dcrs_sync_q[1];
         end else begin
            done_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= 2'b11;
         dcrs_sync_q <= 2'b00;
         sdi_sync_q  <= 2'b00;
         sck_sync_q  <= 3'b000;
         cnt_q       <= 3'd0;
         shift_q     <= 8'h00;
         byte_q      <= 8'h00;
         data_q      <= 1'b0;
         done_q      <= 1'b0;
         stb_q       <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         dcrs_sync_q <= dcrs_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         sck_sync_q  <= sck_sync_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         byte_q      <= byte_d;
         data_q      <= data_d;
         done_q      <= done_d;
         stb_q       <= stb_d;
      end
   end

   assign rx_byte    = byte_q;
   assign rx_is_data = data_q;
   assign rx_stb     = stb_q;

endmodule

// File: rtl/lcd_spi_sink.sv
// LCD-side decoder: turns received bytes into commands and RGB565 pixel
// writes, tracking the column/page window and the write address.
module lcd_spi_sink #(
   parameter int H_RES = 320,
   parameter int V_RES = 240,
   parameter int X_W   = 9,
   parameter int Y_W   = 8
) (
   input  logic           i_clk_100MHz,
   input  logic           i_rst_n,
   input  logic           i_cs,
   input  logic           i_dcrs,
   input  logic           i_sdi,
   input  logic           i_sck,
   input  logic           i_lcdrst,
   output logic           o_cmd_valid,
   output logic [7:0]     o_cmd,
   output logic           o_pix_valid,
   output logic [15:0]    o_pix_data,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_frame_done,
   output logic           o_err
);
   import lcd_pkg::*;

   localparam logic [X_W-1:0] EC_RST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] EP_RST = Y_W'(V_RES - 1);

   logic [1:0]     lcdrst_sync_q, lcdrst_sync_d;
   logic           srst_s;
   logic [7:0]     rx_byte_s;
   logic           rx_is_data_s, rx_stb_s;
   lcd_state_e     state_q, state_d;
   logic [2:0]     pidx_q, pidx_d;
   logic [7:0]     p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic [X_W-1:0] sc_q, sc_d, ec_q, ec_d, x_q, x_d, ox_q, ox_d;
   logic [Y_W-1:0] sp_q, sp_d, ep_q, ep_d, y_q, y_d, oy_q, oy_d;
   logic           half_q, half_d;
   logic [7:0]     hi_q, hi_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic [7:0]     cmd_q, cmd_d;
   logic           pix_valid_q, pix_valid_d;
   logic [15:0]    pix_data_q, pix_data_d;
   logic           frame_done_q, frame_done_d;
   logic           err_q, err_d;
   logic [X_W-1:0] xs_s, xe_s;
   logic [Y_W-1:0] ys_s, ye_s;

   assign srst_s = ~lcdrst_sync_q[1];

   lcd_spi_byte_rx u_byte_rx (
      .clk        (i_clk_100MHz),
      .rst_n      (i_rst_n),
      .srst       (srst_s),
      .cs_n       (i_cs),
      .dcrs       (i_dcrs),
      .sdi        (i_sdi),
      .sck        (i_sck),
      .rx_byte    (rx_byte_s),
      .rx_is_data (rx_is_data_s),
      .rx_stb     (rx_stb_s)
   );

   // The final parameter byte is still on rx_byte_s when the window commits.
   assign xs_s = X_W'({p0_q, p1_q});
   assign xe_s = X_W'({p2_q, rx_byte_s});
   assign ys_s = Y_W'({p0_q, p1_q});
   assign ye_s = Y_W'({p2_q, rx_byte_s});

   // Command dispatch, window parameters and pixel address sequencing.
   always_comb begin
      lcdrst_sync_d = {lcdrst_sync_q[0], i_lcdrst};
      state_d       = state_q;
      pidx_d        = pidx_q;
      p0_d          = p0_q;
      p1_d          = p1_q;
      p2_d          = p2_q;
      sc_d          = sc_q;
      ec_d          = ec_q;
      sp_d          = sp_q;
      ep_d          = ep_q;
      x_d           = x_q;
      y_d           = y_q;
      ox_d          = ox_q;
      oy_d          = oy_q;
      half_d        = half_q;
      hi_d          = hi_q;
      cmd_d         = cmd_q;
      pix_data_d    = pix_data_q;
      cmd_valid_d   = 1'b0;
      pix_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
      err_d         = 1'b0;
      if (srst_s) begin
         state_d    = S_IDLE;
         pidx_d     = 3'd0;
         sc_d       = '0;
         ec_d       = EC_RST;
         sp_d       = '0;
         ep_d       = EP_RST;
         x_d        = '0;
         y_d        = '0;
         ox_d       = '0;
         oy_d       = '0;
         half_d     = 1'b0;
         cmd_d      = 8'h00;
         pix_data_d = 16'h0000;
      end else if (rx_stb_s && !rx_is_data_s) begin
         cmd_valid_d = 1'b1;
         cmd_d       = rx_byte_s;
         half_d      = 1'b0;
         pidx_d      = 3'd0;
         err_d       = half_q;
         case (rx_byte_s)
            CMD_CASET:  state_d = S_CASET;
            CMD_PASET:  state_d = S_PASET;
            CMD_RAMWR: begin
               state_d = S_RAMWR;
               x_d     = sc_q;
               y_d     = sp_q;
            end
            CMD_RAMWRC: state_d = S_RAMWR;
            default:    state_d = S_SKIP;
         endcase
      end else if (rx_stb_s) begin
         case (state_q)
            S_CASET, S_PASET: begin
               case (pidx_q)
                  3'd0: begin p0_d = rx_byte_s; pidx_d = 3'd1; end
                  3'd1: begin p1_d = rx_byte_s; pidx_d = 3'd2; end
                  3'd2: begin p2_d = rx_byte_s; pidx_d = 3'd3; end
                  3'd3: begin
                     pidx_d = 3'd4;
                     if (state_q == S_CASET) begin
                        sc_d = xs_s;
                        ec_d = (xs_s > xe_s) ? xs_s : xe_s;
                     end else begin
                        sp_d = ys_s;
                        ep_d = (ys_s > ye_s) ? ys_s : ye_s;
                     end
                  end
                  default: pidx_d = pidx_q;
               endcase
            end
            S_RAMWR: begin
               if (!half_q) begin
                  hi_d   = rx_byte_s;
                  half_d = 1'b1;
               end else begin
                  half_d      = 1'b0;
                  pix_valid_d = 1'b1;
                  pix_data_d  = {hi_q, rx_byte_s};
                  ox_d        = x_q;
                  oy_d        = y_q;
                  if (x_q == ec_q && y_q == ep_q) begin
                     x_d          = sc_q;
                     y_d          = sp_q;
                     frame_done_d = 1'b1;
                  end else if (x_q == ec_q) begin
                     x_d = sc_q;
                     y_d = y_q + Y_W'(1);
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
               end
            end
            S_SKIP:  err_d = 1'b0;
            S_IDLE:  err_d = 1'b1;
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lcdrst_sync_q <= 2'b11;
         state_q       <= S_IDLE;
         pidx_q        <= 3'd0;
         p0_q          <= 8'h00;
         p1_q          <= 8'h00;
         p2_q          <= 8'h00;
         sc_q          <= '0;
         ec_q          <= EC_RST;
         sp_q          <= '0;
         ep_q          <= EP_RST;
         x_q           <= '0;
         y_q           <= '0;
         ox_q          <= '0;
         oy_q          <= '0;
         half_q        <= 1'b0;
         hi_q          <= 8'h00;
         cmd_valid_q   <= 1'b0;
         cmd_q         <= 8'h00;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= 16'h0000;
         frame_done_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         lcdrst_sync_q <= lcdrst_sync_d;
         state_q       <= state_d;
         pidx_q        <= pidx_d;
         p0_q          <= p0_d;
         p1_q          <= p1_d;
         p2_q          <= p2_d;
         sc_q          <= sc_d;
         ec_q          <= ec_d;
         sp_q          <= sp_d;
         ep_q          <= ep_d;
         x_q           <= x_d;
         y_q           <= y_d;
         ox_q          <= ox_d;
         oy_q          <= oy_d;
         half_q        <= half_d;
         hi_q          <= hi_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_q         <= cmd_d;
         pix_valid_q   <= pix_valid_d;
         pix_data_q    <= pix_data_d;
         frame_done_q  <= frame_done_d;
         err_q         <= err_d;
      end
   end

   assign o_cmd_valid  = cmd_valid_q;
   assign o_cmd        = cmd_q;
   assign o_pix_valid  = pix_valid_q;
   assign o_pix_data   = pix_data_q;
   assign o_x          = ox_q;
   assign o_y          = oy_q;
   assign o_frame_done = frame_done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Directed bench for lcd_spi_sink: drives SPI byte sequences and compares the
// captured pixel/command/error events with hand-computed expectations.
module tb_lcd_spi_sink;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_cs = 1'b1;
   logic        i_dcrs = 1'b0;
   logic        i_sdi = 1'b0;
   logic        i_sck = 1'b0;
   logic        i_lcdrst = 1'b1;
   logic        o_cmd_valid;
   logic [7:0]  o_cmd;
   logic        o_pix_valid;
   logic [15:0] o_pix_data;
   logic [8:0]  o_x;
   logic [7:0]  o_y;
   logic        o_frame_done;
   logic        o_err;

   typedef struct packed {
      logic [15:0] d;
      logic [8:0]  x;
      logic [7:0]  y;
      logic        fd;
   } pix_t;

   pix_t mon_q[$];
   int   err_cnt = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   e0;

   lcd_spi_sink dut (
      .i_clk_100MHz (clk),
      .i_rst_n      (i_rst_n),
      .i_cs         (i_cs),
      .i_dcrs       (i_dcrs),
      .i_sdi        (i_sdi),
      .i_sck        (i_sck),
      .i_lcdrst     (i_lcdrst),
      .o_cmd_valid  (o_cmd_valid),
      .o_cmd        (o_cmd),
      .o_pix_valid  (o_pix_valid),
      .o_pix_data   (o_pix_data),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_frame_done (o_frame_done),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   // Capture output pulses away from the active edge.
   always @(negedge clk) begin
      if (o_pix_valid) mon_q.push_back({o_pix_data, o_x, o_y, o_frame_done});
      if (o_err) err_cnt++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
      i_cs = 1'b0;
      #80;
      for (int i = 0; i < n; i++) begin
         i_dcrs = dc;
         i_sdi  = b[7-i];
         #80 i_sck = 1'b1;
         #80 i_sck = 1'b0;
      end
      i_cs = 1'b1;
      #80;
   endtask

   task automatic cmd(input logic [7:0] b);
      send_bits(1'b0, b, 8);
   endtask

   task automatic dat(input logic [7:0] b);
      send_bits(1'b1, b, 8);
   endtask

   task automatic pix(input logic [15:0] p);
      dat(p[15:8]);
      dat(p[7:0]);
   endtask

   task automatic win4(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
      cmd(c);
      dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
   endtask

   task automatic expect_pix(input string tag, input logic [15:0] d, input logic [8:0] x,
                             input logic [7:0] y, input logic fd);
      pix_t p;
      check_eq({tag, "_present"}, 64'(mon_q.size() > 0), 64'd1);
      if (mon_q.size() > 0) begin
         p = mon_q.pop_front();
         check_eq(tag, 64'(p), 64'({d, x, y, fd}));
      end
   endtask

   task automatic expect_none(input string tag);
      check_eq(tag, 64'(mon_q.size()), 64'd0);
      mon_q.delete();
   endtask

   initial begin
      #32 i_rst_n = 1'b1;
      #100;
      check_eq("rst_cmd", 64'(o_cmd), 64'h0);
      check_eq("rst_xy", 64'({o_x, o_y}), 64'h0);
      check_eq("rst_pulses", 64'({o_pix_valid, o_cmd_valid, o_frame_done, o_err}), 64'h0);

      // Basic memory write from reset.
      e0 = err_cnt;
      cmd(8'h2C);
      check_eq("cmd_2c", 64'(o_cmd), 64'h2C);
      pix(16'hF800);
      pix(16'h07E0);
      #200;
      expect_pix("t1_p0", 16'hF800, 9'd0, 8'd0, 1'b0);
      expect_pix("t1_p1", 16'h07E0, 9'd1, 8'd0, 1'b0);
      expect_none("t1_extra");
      check_eq("t1_err", 64'(err_cnt), 64'(e0));

      // 2x2 window, wrap and frame done.
      win4(8'h2A, 16'd10, 16'd11);
      win4(8'h2B, 16'd5, 16'd6);
      cmd(8'h2C);
      pix(16'h1111); pix(16'h2222); pix(16'h3333); pix(16'h4444); pix(16'h5555);
      #200;
      expect_pix("t2_p0", 16'h1111, 9'd10, 8'd5, 1'b0);
      expect_pix("t2_p1", 16'h2222, 9'd11, 8'd5, 1'b0);
      expect_pix("t2_p2", 16'h3333, 9'd10, 8'd6, 1'b0);
      expect_pix("t2_p3", 16'h4444, 9'd11, 8'd6, 1'b1);
      expect_pix("t2_p4", 16'h5555, 9'd10, 8'd5, 1'b0);
      expect_none("t2_extra");

      // Restore full window, then write-continue versus a fresh write.
      win4(8'h2A, 16'd0, 16'd319);
      win4(8'h2B, 16'd0, 16'd239);
      cmd(8'h2C); pix(16'hAAAA);
      cmd(8'h3C); pix(16'hBBBB);
      cmd(8'h2C); pix(16'hCCCC);
      #200;
      expect_pix("t3_ramwr", 16'hAAAA, 9'd0, 8'd0, 1'b0);
      expect_pix("t3_cont", 16'hBBBB, 9'd1, 8'd0, 1'b0);
      expect_pix("t3_restart", 16'hCCCC, 9'd0, 8'd0, 1'b0);

      // start > end clamps end to start; a short parameter list changes nothing.
      win4(8'h2A, 16'd5, 16'd2);
      cmd(8'h2C); pix(16'h0101); pix(16'h0202);
      cmd(8'h2A); dat(8'h00); dat(8'h07);
      cmd(8'h2C); pix(16'h0303);
      #200;
      expect_pix("t3_clamp0", 16'h0101, 9'd5, 8'd0, 1'b0);
      expect_pix("t3_clamp1", 16'h0202, 9'd5, 8'd1, 1'b0);
      expect_pix("t3_short", 16'h0303, 9'd5, 8'd0, 1'b0);
      win4(8'h2A, 16'd0, 16'd319);

      // Partial byte discarded by cs.
      e0 = err_cnt;
      cmd(8'h2C);
      send_bits(1'b1, 8'hFF, 5);
      pix(16'h1234);
      #200;
      expect_pix("t4_pix", 16'h1234, 9'd0, 8'd0, 1'b0);
      expect_none("t4_extra");
      check_eq("t4_err", 64'(err_cnt), 64'(e0));

      // Half pixel dropped by a command; unknown command skips data.
      e0 = err_cnt;
      cmd(8'h2C); dat(8'hAB); cmd(8'h00);
      #200;
      check_eq("t5_err", 64'(err_cnt), 64'(e0 + 1));
      check_eq("t5_cmd", 64'(o_cmd), 64'h00);
      dat(8'h11); dat(8'h22);
      #200;
      expect_none("t5_nopix");
      check_eq("t5_skip_err", 64'(err_cnt), 64'(e0 + 1));

      // Data from reset is an error.
      i_rst_n = 1'b0;
      #100 i_rst_n = 1'b1;
      #100;
      e0 = err_cnt;
      dat(8'h55);
      #200;
      check_eq("t5_idle_err", 64'(err_cnt), 64'(e0 + 1));
      expect_none("t5_idle_nopix");

      // Soft reset mid-frame.
      win4(8'h2A, 16'd10, 16'd11);
      win4(8'h2B, 16'd5, 16'd6);
      cmd(8'h2C); pix(16'h7777); dat(8'h01);
      #200;
      expect_pix("t6_pre", 16'h7777, 9'd10, 8'd5, 1'b0);
      i_lcdrst = 1'b0;
      #100;
      check_eq("t6_srst_xy", 64'({o_x, o_y}), 64'h0);
      check_eq("t6_srst_cmd", 64'(o_cmd), 64'h0);
      i_lcdrst = 1'b1;
      #100;
      cmd(8'h2C); pix(16'h8888); pix(16'h9999);
      #200;
      expect_pix("t6_post0", 16'h8888, 9'd0, 8'd0, 1'b0);
      expect_pix("t6_post1", 16'h9999, 9'd1, 8'd0, 1'b0);

      // Asynchronous hard reset mid-frame.
      win4(8'h2A, 16'd10, 16'd11);
      cmd(8'h2C); pix(16'h4242);
      #200;
      expect_pix("t7_pre", 16'h4242, 9'd10, 8'd0, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check_eq("t7_async_xy", 64'({o_x, o_y}), 64'h0);
      check_eq("t7_async_cmd", 64'(o_cmd), 64'h0);
      #99 i_rst_n = 1'b1;
      #100;
      cmd(8'h2C); pix(16'h5A5A);
      #200;
      expect_pix("t7_post", 16'h5A5A, 9'd0, 8'd0, 1'b0);
      expect_none("t7_extra");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
